// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - grade encodings, default point values and bonus-width helper for the score tracker
package score_pkg;

  localparam logic [1:0] GRADE_NONE    = 2'b00;
  localparam logic [1:0] GRADE_GOOD    = 2'b01;
  localparam logic [1:0] GRADE_PERFECT = 2'b10;
  localparam logic [1:0] GRADE_MISS    = 2'b11;

  localparam int DEF_PERFECT_PTS  = 3;
  localparam int DEF_GOOD_PTS     = 1;
  localparam int DEF_MISS_PENALTY = 1;

  // Width of the bonus tier output; kept at least 1 so MAX_BONUS=0 still yields a legal port.
  function automatic int bonus_w(input int max_bonus);
    return (max_bonus < 1) ? 1 : $clog2(max_bonus + 1);
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// rtl/sat_add_signed.sv - signed adder clamping to the W-bit two's complement range
module sat_add_signed #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W:0] wide;

  // One guard bit: overflow exactly when the top two bits of the wide sum disagree.
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    ovf  = wide[W] ^ wide[W-1];
    if (ovf) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule

// File: rtl/score_combo_tracker.sv
// rtl/score_combo_tracker.sv - saturating score, combo, best combo and bonus tier from graded hits
// Optional SCORE_HIT_STATS_EN adds per-grade saturating hit counters.
module score_combo_tracker
  import score_pkg::*;
#(
  parameter int SCORE_W      = 16,
  parameter int COMBO_W      = 8,
  parameter int PERFECT_PTS  = DEF_PERFECT_PTS,
  parameter int GOOD_PTS     = DEF_GOOD_PTS,
  parameter int MISS_PENALTY = DEF_MISS_PENALTY,
  parameter int COMBO_STEP   = 10,
  parameter int MAX_BONUS    = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            hit_valid,
  input  logic [1:0]                      hit_grade,
  output logic signed [SCORE_W-1:0]       score,
  output logic [COMBO_W-1:0]              combo,
  output logic [COMBO_W-1:0]              max_combo,
  output logic [bonus_w(MAX_BONUS)-1:0]   bonus,
  output logic                            sat
`ifdef SCORE_HIT_STATS_EN
  ,
  output logic [COMBO_W-1:0]              perfect_cnt,
  output logic [COMBO_W-1:0]              good_cnt,
  output logic [COMBO_W-1:0]              miss_cnt
`endif
);

  localparam int BONUS_W = bonus_w(MAX_BONUS);
  localparam int STEP_W  = (COMBO_STEP < 2) ? 1 : $clog2(COMBO_STEP);
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
  localparam logic [BONUS_W-1:0] BONUS_MAX = BONUS_W'(MAX_BONUS);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(COMBO_STEP - 1);

  if ((GOOD_PTS + MAX_BONUS) >= (1 << (SCORE_W - 1)) ||
      (PERFECT_PTS + MAX_BONUS) >= (1 << (SCORE_W - 1))) begin : g_bad_points
    $error("score_combo_tracker: per-hit points do not fit in SCORE_W-1 bits");
  end
  if (COMBO_STEP < 1) begin : g_bad_step
    $error("score_combo_tracker: COMBO_STEP must be at least 1");
  end

  logic                      is_hit;
  logic                      is_miss;
  logic signed [SCORE_W-1:0] delta;
  logic signed [SCORE_W-1:0] score_sum;
  logic                      score_ovf;
  logic [COMBO_W-1:0]        combo_next;
  logic [STEP_W-1:0]         step_cnt;

  always_comb begin
    is_hit  = hit_valid && (hit_grade == GRADE_GOOD || hit_grade == GRADE_PERFECT);
    is_miss = hit_valid && (hit_grade == GRADE_MISS);
    delta   = '0;
    if (hit_grade == GRADE_PERFECT) begin
      delta = SCORE_W'(PERFECT_PTS) + SCORE_W'(bonus);
    end else if (hit_grade == GRADE_GOOD) begin
      delta = SCORE_W'(GOOD_PTS) + SCORE_W'(bonus);
    end else if (hit_grade == GRADE_MISS) begin
      delta = -SCORE_W'(MISS_PENALTY);
    end
    combo_next = (combo == COMBO_MAX) ? combo : combo + 1'b1;
  end

  sat_add_signed #(.W(SCORE_W)) u_score_add (
    .a   (score),
    .b   (delta),
    .sum (score_sum),
    .ovf (score_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
      bonus     <= '0;
      sat       <= 1'b0;
      step_cnt  <= '0;
    end else if (is_miss) begin
      score    <= score_sum;
      sat      <= sat | score_ovf;
      combo    <= '0;
      bonus    <= '0;
      step_cnt <= '0;
    end else if (is_hit) begin
      score <= score_sum;
      sat   <= sat | score_ovf;
      combo <= combo_next;
      if (combo_next > max_combo) max_combo <= combo_next;
      // Step counter keeps cycling after the tier cap; only the tier itself stops.
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        if (bonus < BONUS_MAX) bonus <= bonus + 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

`ifdef SCORE_HIT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      perfect_cnt <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
    end else if (hit_valid) begin
      if (hit_grade == GRADE_PERFECT && perfect_cnt != COMBO_MAX) perfect_cnt <= perfect_cnt + 1'b1;
      if (hit_grade == GRADE_GOOD && good_cnt != COMBO_MAX) good_cnt <= good_cnt + 1'b1;
      if (hit_grade == GRADE_MISS && miss_cnt != COMBO_MAX) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_score_combo_tracker.sv
// tb/tb_score_combo_tracker.sv - self-checking bench for score_combo_tracker against a behavioural score model
module tb_score_combo_tracker;
  import score_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, clear, hit_valid;
  logic [1:0]         hit_grade;
  logic signed [15:0] score;
  logic [7:0]         combo, max_combo;
  logic [1:0]         bonus;
  logic               sat;

  logic               reset_s, clear_s, hit_valid_s;
  logic [1:0]         hit_grade_s;
  logic signed [3:0]  score_s;
  logic [7:0]         combo_s, max_combo_s;
  logic [1:0]         bonus_s;
  logic               sat_s;

`ifdef SCORE_HIT_STATS_EN
  logic [7:0] perfect_cnt, good_cnt, miss_cnt;
  logic [7:0] perfect_cnt_s, good_cnt_s, miss_cnt_s;
`endif

  score_combo_tracker dut (
    .clk(clk), .reset(reset), .clear(clear), .hit_valid(hit_valid), .hit_grade(hit_grade),
    .score(score), .combo(combo), .max_combo(max_combo), .bonus(bonus), .sat(sat)
`ifdef SCORE_HIT_STATS_EN
    , .perfect_cnt(perfect_cnt), .good_cnt(good_cnt), .miss_cnt(miss_cnt)
`endif
  );

  score_combo_tracker #(.SCORE_W(4)) dut_small (
    .clk(clk), .reset(reset_s), .clear(clear_s), .hit_valid(hit_valid_s), .hit_grade(hit_grade_s),
    .score(score_s), .combo(combo_s), .max_combo(max_combo_s), .bonus(bonus_s), .sat(sat_s)
`ifdef SCORE_HIT_STATS_EN
    , .perfect_cnt(perfect_cnt_s), .good_cnt(good_cnt_s), .miss_cnt(miss_cnt_s)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integers; bonus derived from the current combo length.
  int m_score, m_combo, m_max, m_pc, m_gc, m_mc;
  bit m_sat;

  function automatic int bonus_of(input int c);
    return (c / 10 > 3) ? 3 : c / 10;
  endfunction

  function automatic int inc_sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  function automatic void model_step(input bit r, input bit c, input bit v, input logic [1:0] g);
    if (r || c) begin
      m_score = 0; m_combo = 0; m_max = 0; m_sat = 0; m_pc = 0; m_gc = 0; m_mc = 0;
    end else if (v && g != GRADE_NONE) begin
      if (g == GRADE_MISS) begin
        m_score = m_score - 1;
        m_combo = 0;
        m_mc = inc_sat(m_mc);
      end else begin
        m_score = m_score + ((g == GRADE_PERFECT) ? 3 : 1) + bonus_of(m_combo);
        m_combo = inc_sat(m_combo);
        if (g == GRADE_PERFECT) m_pc = inc_sat(m_pc); else m_gc = inc_sat(m_gc);
      end
      if (m_score > 32767) begin m_score = 32767; m_sat = 1; end
      if (m_score < -32768) begin m_score = -32768; m_sat = 1; end
      if (m_combo > m_max) m_max = m_combo;
    end
  endfunction

  function automatic logic [34:0] exp_vec();
    logic [15:0] s;
    logic [7:0]  c, mx;
    s  = 16'(m_score);
    c  = 8'(m_combo);
    mx = 8'(m_max);
    return {s, c, mx, 2'(bonus_of(m_combo)), m_sat};
  endfunction

  task automatic cyc(input bit r, input bit c, input bit v, input logic [1:0] g);
    @(negedge clk);
    reset = r; clear = c; hit_valid = v; hit_grade = g;
    @(posedge clk);
    #1;
    reset = 0; clear = 0; hit_valid = 0; hit_grade = GRADE_NONE;
    model_step(r, c, v, g);
  endtask

  task automatic cyc_s(input bit c, input bit v, input logic [1:0] g);
    @(negedge clk);
    clear_s = c; hit_valid_s = v; hit_grade_s = g;
    @(posedge clk);
    #1;
    clear_s = 0; hit_valid_s = 0; hit_grade_s = GRADE_NONE;
  endtask

  task automatic test_reset();
    cyc(1, 0, 1, GRADE_PERFECT);
    cyc(1, 0, 0, GRADE_NONE);
    n_cmp++;
    if ({score, combo, max_combo, bonus, sat} !== 35'd0) begin
      n_bad++; $display("FAIL reset_state: got %h expected 0", {score, combo, max_combo, bonus, sat});
    end
  endtask

  task automatic test_perfect_run();
    cyc(1, 0, 0, GRADE_NONE);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      hit_valid = 1; hit_grade = GRADE_PERFECT;
      #2;
      n_cmp++;
      if (score !== 16'(3 * (i - 1))) begin
        n_bad++; $display("FAIL perfect_latency hit %0d: score %0d expected %0d", i, score, 3 * (i - 1));
      end
      @(posedge clk);
      #1;
      hit_valid = 0; hit_grade = GRADE_NONE;
      model_step(0, 0, 1, GRADE_PERFECT);
      n_cmp++;
      if (score !== 16'(3 * i) || combo !== 8'(i) || max_combo !== 8'(i) || bonus !== 2'd0) begin
        n_bad++; $display("FAIL perfect_run hit %0d: score=%0d combo=%0d max=%0d bonus=%0d expected %0d/%0d/%0d/0",
                          i, score, combo, max_combo, bonus, 3 * i, i, i);
      end
    end
  endtask

  task automatic test_good_then_perfect();
    cyc(1, 0, 0, GRADE_NONE);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, GRADE_GOOD);
    n_cmp++;
    if (score !== 16'sd10 || bonus !== 2'd1) begin
      n_bad++; $display("FAIL ten_goods: score=%0d bonus=%0d expected 10/1", score, bonus);
    end
    cyc(0, 0, 1, GRADE_PERFECT);
    n_cmp++;
    if (score !== 16'sd14 || combo !== 8'd11) begin
      n_bad++; $display("FAIL good_then_perfect: score=%0d combo=%0d expected 14/11", score, combo);
    end
  endtask

  task automatic test_bonus_climb();
    cyc(1, 0, 0, GRADE_NONE);
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 1, GRADE_PERFECT);
      n_cmp++;
      if (bonus !== 2'(bonus_of(i)) || {score, combo, max_combo, bonus, sat} !== exp_vec()) begin
        n_bad++; $display("FAIL bonus_climb hit %0d: got %h expected %h", i,
                          {score, combo, max_combo, bonus, sat}, exp_vec());
      end
    end
    n_cmp++;
    if (score !== 16'sd180 || bonus !== 2'd3) begin
      n_bad++; $display("FAIL bonus_climb_total: score=%0d bonus=%0d expected 180/3", score, bonus);
    end
  endtask

  task automatic test_miss_break();
    cyc(1, 0, 0, GRADE_NONE);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, GRADE_GOOD);
    cyc(0, 0, 1, GRADE_MISS);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, GRADE_GOOD);
    n_cmp++;
    if (score !== 16'sd9 || combo !== 8'd3 || max_combo !== 8'd7 || bonus !== 2'd0) begin
      n_bad++; $display("FAIL miss_break: score=%0d combo=%0d max=%0d bonus=%0d expected 9/3/7/0",
                        score, combo, max_combo, bonus);
    end
  endtask

  task automatic test_saturation();
    int exp_s;
    @(negedge clk); reset_s = 1;
    @(posedge clk); #1; reset_s = 0;
    exp_s = 0;
    for (int i = 1; i <= 3; i++) begin
      cyc_s(0, 1, GRADE_PERFECT);
      exp_s = (exp_s + 3 > 7) ? 7 : exp_s + 3;
      n_cmp++;
      if (score_s !== 4'(exp_s) || sat_s !== (i == 3)) begin
        n_bad++; $display("FAIL sat_high hit %0d: score=%0d sat=%0b expected %0d/%0b", i, score_s, sat_s, exp_s, i == 3);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      cyc_s(0, 1, GRADE_MISS);
      exp_s = (exp_s - 1 < -8) ? -8 : exp_s - 1;
    end
    n_cmp++;
    if (score_s !== 4'sb1000 || sat_s !== 1'b1 || exp_s != -8) begin
      n_bad++; $display("FAIL sat_low: score=%0d sat=%0b expected -8/1", score_s, sat_s);
    end
    cyc_s(1, 0, GRADE_NONE);
    n_cmp++;
    if ({score_s, combo_s, max_combo_s, bonus_s, sat_s} !== 23'd0) begin
      n_bad++; $display("FAIL sat_clear: got %h expected 0", {score_s, combo_s, max_combo_s, bonus_s, sat_s});
    end
  endtask

  task automatic test_clear_priority();
    cyc(1, 0, 0, GRADE_NONE);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, GRADE_GOOD);
    cyc(0, 0, 1, GRADE_NONE);
    n_cmp++;
    if (score !== 16'sd4 || combo !== 8'd4 || max_combo !== 8'd4) begin
      n_bad++; $display("FAIL grade00_no_change: score=%0d combo=%0d max=%0d expected 4/4/4", score, combo, max_combo);
    end
    cyc(0, 1, 1, GRADE_PERFECT);
    n_cmp++;
    if ({score, combo, max_combo, bonus, sat} !== 35'd0) begin
      n_bad++; $display("FAIL clear_over_hit: got %h expected 0", {score, combo, max_combo, bonus, sat});
    end
  endtask

  task automatic test_combo_saturate();
    cyc(1, 0, 0, GRADE_NONE);
    for (int i = 0; i < 260; i++) cyc(0, 0, 1, GRADE_PERFECT);
    n_cmp++;
    if (combo !== 8'd255 || max_combo !== 8'd255 || bonus !== 2'd3 || {score, combo, max_combo, bonus, sat} !== exp_vec()) begin
      n_bad++; $display("FAIL combo_saturate: got %h expected %h", {score, combo, max_combo, bonus, sat}, exp_vec());
    end
  endtask

  task automatic test_back_to_back_random();
    bit r, c, v;
    logic [1:0] g;
    cyc(1, 0, 0, GRADE_NONE);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      g = 2'($urandom_range(0, 9) < 2 ? 3 : $urandom_range(0, 2));
      cyc(r, c, v, g);
      n_cmp++;
      if ({score, combo, max_combo, bonus, sat} !== exp_vec()) begin
        n_bad++; $display("FAIL random step %0d: got %h expected %h", i, {score, combo, max_combo, bonus, sat}, exp_vec());
      end
`ifdef SCORE_HIT_STATS_EN
      n_cmp++;
      if ({perfect_cnt, good_cnt, miss_cnt} !== {8'(m_pc), 8'(m_gc), 8'(m_mc)}) begin
        n_bad++; $display("FAIL random_stats step %0d: got %h expected %h", i,
                          {perfect_cnt, good_cnt, miss_cnt}, {8'(m_pc), 8'(m_gc), 8'(m_mc)});
      end
`endif
    end
  endtask

  initial begin
    reset = 1; clear = 0; hit_valid = 0; hit_grade = GRADE_NONE;
    reset_s = 1; clear_s = 0; hit_valid_s = 0; hit_grade_s = GRADE_NONE;
    model_step(1, 0, 0, GRADE_NONE);
    test_reset();
    test_perfect_run();
    test_good_then_perfect();
    test_bonus_climb();
    test_miss_break();
    test_saturation();
    test_clear_priority();
    test_combo_saturate();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
